// File: rtl/tx_channel_arbiter_if.sv
// Transmit-channel bundle: requester side plus the shared byte channel pins.
// The master modport is the user/sink environment, the slave is the arbiter.
interface tx_channel_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic               txready;
    logic [DW-1:0]      txdata;
    logic               txclk;
    logic               busy;
    logic [IW-1:0]      grant_id;

    modport master (
        output req, req_data, txready,
        input  ack, txdata, txclk, busy, grant_id
    );

    modport slave (
        input  req, req_data, txready,
        output ack, txdata, txclk, busy, grant_id
    );
endinterface

// File: rtl/tx_channel_arbiter.sv
// Round-robin arbiter sharing one byte-wide transmit channel between NREQ
// requesters; each grant runs a setup / strobe / gap sequence on txclk.
module tx_channel_arbiter #(
    parameter int NREQ       = 4,
    parameter int DW         = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int GAP_CYC    = 1
) (
    input logic hz100,
    input logic reset,
    tx_channel_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = 8;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [IW-1:0] nxt;
    logic          found;

    // First requester at or after the pointer, wrapping modulo NREQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign nxt = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            ptr          <= '0;
            bus.ack      <= '0;
            bus.txdata   <= '0;
            bus.txclk    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.grant_id <= '0;
        end else begin
            bus.ack <= '0;
            unique case (state)
                IDLE: begin
                    if (bus.txready && found) begin
                        bus.txdata   <= bus.req_data[int'(win)*DW +: DW];
                        bus.ack      <= NREQ'(1) << win;
                        bus.grant_id <= win;
                        ptr          <= nxt;
                        bus.busy     <= 1'b1;
                        cnt          <= CW'(SETUP_CYC);
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt <= CW'(1)) begin
                        cnt       <= CW'(STROBE_CYC);
                        bus.txclk <= 1'b1;
                        state     <= STROBE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt <= CW'(1)) begin
                        cnt       <= CW'(GAP_CYC);
                        bus.txclk <= 1'b0;
                        state     <= GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt <= CW'(1)) begin
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
